// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes, the dump FSM state type and a register-slice
//            helper. The slice helper always reports the zero register (XZR)
//            as 0.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] XZR_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } dump_state_t;

  // One register from the flattened storage bus; XZR always reads as zero.
  function automatic logic [DATA_WIDTH-1:0] reg_slice(
    input logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    input logic [ADDR_WIDTH-1:0]          idx
  );
    if (idx == XZR_IDX) begin
      return '0;
    end
    return regs[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_counter.sv
`default_nettype none
// ============================================================================
// Module   : dump_addr_counter
// Purpose  : Walk pointer for the dump reader. Loads the first index and
//            latches the last index together, steps modulo NUM_REGS on
//            enable, and flags when the current index is the last one.
// Revision : 1.0 - initial release
// ============================================================================
module dump_addr_counter #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_first,
  input  logic [ADDR_WIDTH-1:0] load_last,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic [ADDR_WIDTH-1:0] next_count,
  output logic                  at_last
);

  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_top_idx = ADDR_WIDTH'(NUM_REGS - 1);

  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] w_next;

  // Successor index wraps from the top register back to index 0.
  assign w_next = (count_q == c_top_idx) ? '0 : count_q + 1'b1;

  // Load has priority over stepping; both the pointer and the bound update on load.
  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    if (load) begin
      count_d = load_first;
      last_d  = load_last;
    end else if (en) begin
      count_d = w_next;
    end
  end

  // Pointer and latched bound, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      last_q  <= '0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign count      = count_q;
  assign next_count = w_next;
  assign at_last    = (count_q == last_q);

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Streams (address, data) pairs for a programmable, wrapping range
//            of architectural registers over a valid/ready interface. Each
//            beat's data is a snapshot taken when the beat is loaded.
// Options  : REGFILE_DUMP_SKIP_ZERO_EN - when defined, zero-valued registers
//            are examined (one per cycle) but produce no beat.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          first_addr,
  input  logic [ADDR_WIDTH-1:0]          last_addr,
  input  logic                           abort,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           busy,
  output logic                           done
);

  import regfile_pkg::*;

  dump_state_t           state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  w_load;
  logic                  w_adv_en;
  logic                  w_advance;
  logic                  w_at_last;
  logic                  w_beat_ok;
  logic [ADDR_WIDTH-1:0] w_count;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [ADDR_WIDTH-1:0] w_load_idx;
  logic [DATA_WIDTH-1:0] w_load_data;

  dump_addr_counter #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_first (first_addr),
    .load_last  (last_addr),
    .en         (w_adv_en),
    .count      (w_count),
    .next_count (w_next),
    .at_last    (w_at_last)
  );

  // A new dump starts only from IDLE, and abort in the same cycle vetoes it.
  assign w_load = (state_q == IDLE) && start && !abort;

  // The walk moves on when the current beat is taken, or when there is no
  // beat pending (an index skipped as zero).
  assign w_advance = !valid_q || out_ready;
  assign w_adv_en  = (state_q == STREAM) && !abort && w_advance && !w_at_last;

  // Index whose value is captured this cycle: first on start, successor otherwise.
  assign w_load_idx = w_load ? first_addr : w_next;

  generate
    if (NUM_REGS == regfile_pkg::NUM_REGS && DATA_WIDTH == regfile_pkg::DATA_WIDTH &&
        ADDR_WIDTH == regfile_pkg::ADDR_WIDTH) begin : g_pkg_slice
      assign w_load_data = reg_slice(regs, w_load_idx);
    end else begin : g_local_slice
      localparam logic [ADDR_WIDTH-1:0] c_xzr_idx = ADDR_WIDTH'(NUM_REGS - 1);
      assign w_load_data = (w_load_idx == c_xzr_idx) ? '0 :
                           regs[int'(w_load_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  assign w_beat_ok = |w_load_data;
`else
  assign w_beat_ok = 1'b1;
`endif

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (w_load) begin
          state_d = STREAM;
          valid_d = w_beat_ok;
          data_d  = w_load_data;
          busy_d  = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (w_advance) begin
          if (w_at_last) begin
            state_d = FINISH;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            valid_d = w_beat_ok;
            data_d  = w_load_data;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = w_count;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Self-checking bench for regfile_dump_reader: a queue-based
//            reference model compared every cycle, plus literal beat logs.
// Options  : REGFILE_DUMP_SKIP_ZERO_EN changes the expected beat count of
//            the zero-skip scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

  localparam int NR = 32;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] tb_regs [NR];
  logic [NR*DW-1:0] regs_bus;

  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_dump_reader #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .regs       (regs_bus),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  // Flatten the bench register array onto the storage bus.
  always_comb begin
    regs_bus = '0;
    for (int i = 0; i < NR; i++) regs_bus[i*DW +: DW] = tb_regs[i];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural value of register i (the top register reads as zero).
  function automatic logic [DW-1:0] mval(input int i);
    return (i == NR - 1) ? '0 : tb_regs[i];
  endfunction

  // ---------------- reference model ----------------
  // Holds the list of indices still to be visited and the beat on display.
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_done = 1'b0;
  logic          m_was_done = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_q[$];
  int            m_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
      m_addr = '0;   m_data = '0;    m_q.delete();
    end else begin
      m_was_done = m_done;
      m_done = 1'b0;
      if (m_busy) begin
        if (abort) begin
          m_busy = 1'b0; m_valid = 1'b0; m_q.delete();
        end else if (!m_valid || out_ready) begin
          if (m_q.size() == 0) begin
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b1;
          end else begin
            m_addr = AW'(m_q.pop_front());
            m_data = mval(int'(m_addr));
            m_valid = 1'b1;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
            m_valid = (m_data != '0);
`endif
          end
        end
      end else if (!m_was_done && start && !abort) begin
        m_idx = int'(first_addr);
        forever begin
          m_q.push_back(m_idx);
          if (m_idx == int'(last_addr)) break;
          m_idx = (m_idx + 1) % NR;
        end
        m_addr = AW'(m_q.pop_front());
        m_data = mval(int'(m_addr));
        m_valid = 1'b1;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
        m_valid = (m_data != '0);
`endif
        m_busy = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    chk("out_valid", DW'(out_valid), DW'(m_valid));
    chk("busy", DW'(busy), DW'(m_busy));
    chk("done", DW'(done), DW'(m_done));
    if (m_valid) begin
      chk("out_addr", DW'(out_addr), DW'(m_addr));
      chk("out_data", out_data, m_data);
    end
  end

  // Log of accepted beats and done pulses for literal checks.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      log_addr.push_back(out_addr);
      log_data.push_back(out_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int f, input int l);
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, DW'(seen), DW'(1'b1));
  endtask

  task automatic chk_beats(input string tag, input int exp_addr[$]);
    chk({tag, "_beat_count"}, DW'(log_addr.size()), DW'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < log_addr.size()) chk({tag, "_beat_addr"}, DW'(log_addr[k]), DW'(exp_addr[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) tb_regs[i] = 64'h0123_4567_0000_0000 | 64'(i + 1);
    tb_regs[NR-1] = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_addr", DW'(out_addr), 0);
    chk("rst_data", out_data, 0);
    reset = 1'b0;
    step();

    // Plain range 3..6, consumer always ready
    clear_log();
    out_ready = 1'b1;
    pulse_start(3, 6);
    chk("t1_first_addr", DW'(out_addr), 3);
    run_until_done("t1", 20);
    step();
    chk_beats("t1", '{3, 4, 5, 6});
    if (log_data.size() > 0) chk("t1_data3", log_data[0], 64'h0123_4567_0000_0004);
    chk("t1_done_cnt", DW'(done_cnt), 1);
    chk("t1_busy_end", DW'(busy), 0);

    // Wrapping range 30..1; start held high through busy and FINISH is ignored
    clear_log();
    first_addr = 5'd30;
    last_addr  = 5'd1;
    start = 1'b1;
    step();
    run_until_done("t2", 20);
    step();
    start = 1'b0;
    step();
    step();
    chk_beats("t2", '{30, 31, 0, 1});
    if (log_data.size() > 1) chk("t2_xzr_data", log_data[1], 0);
    if (log_data.size() > 0) chk("t2_data30", log_data[0], 64'h0123_4567_0000_001F);
    chk("t2_done_cnt", DW'(done_cnt), 1);

    // Single beat 7..7 stalled four cycles while regs[7] and start change
    clear_log();
    out_ready = 1'b0;
    pulse_start(7, 7);
    tb_regs[7] = 64'hDEAD_BEEF_CAFE_0007;
    first_addr = 5'd0;
    last_addr  = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t3_stall_addr", DW'(out_addr), 7);
    chk("t3_stall_data", out_data, 64'h0123_4567_0000_0008);
    step();
    out_ready = 1'b1;
    run_until_done("t3", 10);
    step();
    chk_beats("t3", '{7});
    if (log_data.size() > 0) chk("t3_data", log_data[0], 64'h0123_4567_0000_0008);
    chk("t3_done_cnt", DW'(done_cnt), 1);
    tb_regs[7] = 64'h0123_4567_0000_0008;

    // Abort on the second beat of 0..10, then restart at 5..6
    clear_log();
    out_ready = 1'b1;
    pulse_start(0, 10);
    step();
    abort = 1'b1;
    out_ready = 1'b0;
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    chk("t4_abort_valid", DW'(out_valid), 0);
    chk("t4_abort_busy", DW'(busy), 0);
    chk("t4_abort_done_cnt", DW'(done_cnt), 0);
    pulse_start(5, 6);
    chk("t4_restart_addr", DW'(out_addr), 5);
    chk("t4_restart_valid", DW'(out_valid), 1);
    run_until_done("t4", 20);
    step();
    chk_beats("t4", '{0, 5, 6});
    chk("t4_done_cnt", DW'(done_cnt), 1);

    // Abort and start together in IDLE: nothing starts
    clear_log();
    first_addr = 5'd2;
    last_addr  = 5'd3;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_busy", DW'(busy), 0);
    repeat (3) step();
    chk("t5_beats", DW'(log_addr.size()), 0);

    // Asynchronous reset between clock edges mid-dump
    clear_log();
    out_ready = 1'b1;
    pulse_start(0, 20);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", DW'(out_valid), 0);
    chk("t6_busy", DW'(busy), 0);
    chk("t6_done", DW'(done), 0);
    chk("t6_addr", DW'(out_addr), 0);
    chk("t6_data", out_data, 0);
    clear_log();
    step();
    reset = 1'b0;
    repeat (10) step();
    chk("t6_beats_after", DW'(log_addr.size()), 0);
    chk("t6_done_after", DW'(done_cnt), 0);

    // Zero-valued registers in range 0..4 (only 1 and 3 non-zero)
    tb_regs[0] = '0;
    tb_regs[2] = '0;
    tb_regs[4] = '0;
    clear_log();
    pulse_start(0, 4);
    run_until_done("t7", 20);
    step();
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
    chk_beats("t7", '{1, 3});
`else
    chk_beats("t7", '{0, 1, 2, 3, 4});
`endif
    chk("t7_done_cnt", DW'(done_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side companion to the enabled-flop register file. It walks a programmable range of architectural registers and streams each (address, data) pair out over a valid/ready interface, one register per accepted beat. It is used for debug readback and for end-of-test register checks. It sits beside the register file and observes the flattened storage bus. It never writes.

Parameters:
NUM_REGS, 32, number of architectural registers.
DATA_WIDTH, 64, bits per register.
ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
regs  input  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
start  input  1  single-cycle request to begin a dump; honoured only when busy=0.
first_addr  input  ADDR_WIDTH  first index to dump; sampled on an accepted start.
last_addr  input  ADDR_WIDTH  last index to dump; sampled on an accepted start.
abort  input  1  synchronous cancel of an in-progress dump.
out_ready  input  1  consumer can accept a beat.
out_valid  output  1  beat present.
out_addr  output  ADDR_WIDTH  register index of the beat.
out_data  output  DATA_WIDTH  register value of the beat.
busy  output  1  dump in progress (start through final handshake).
done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset value of every output is 0. Reset is asynchronous and active-high, and may be asserted mid-dump. It clears the FSM to IDLE and clears all latched addresses. No done pulse is produced.
- FSM states: IDLE, STREAM, FINISH.
- IDLE, start=1: latch first/last, set busy=1, go to STREAM.
  - On the next cycle: out_valid=1, out_addr=first, out_data=regs[first]. Start-to-first-beat latency is 1 cycle.
- STREAM, handshake rule: a beat transfers on a cycle with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_addr and out_data are held stable. out_data is a snapshot taken when the beat is loaded; later changes on regs do not alter it.
- STREAM, handshake and out_addr != last: load the next index on the following cycle.
  - Next index is (out_addr+1) mod NUM_REGS.
  - With out_ready held high the block sustains one beat per cycle.
- STREAM, handshake and out_addr == last: out_valid=0, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, go to IDLE. A start arriving in FINISH is ignored.
- Wrap-around: if first > last, the walk proceeds first..NUM_REGS-1, then 0..last. If first == last, exactly one beat is produced.
- Zero register: index NUM_REGS-1 (XZR) is always reported as data 0, whatever the regs bus holds.
- start while busy=1: ignored; latched range unchanged.
- abort=1 in STREAM or FINISH: next state IDLE, out_valid=0, busy=0, no done pulse.
- abort and start in the same IDLE cycle: abort wins; no dump begins.
- start and out_ready have no effect in IDLE other than as described above.

Optional Feature:
Macro: REGFILE_DUMP_SKIP_ZERO_EN.
- Defined:
  - In STREAM the block examines one index per cycle. An index whose value (after the XZR rule) is zero produces no beat: out_valid stays 0 and the walk advances.
  - The walk still terminates at last. If last itself is zero, the block goes to FINISH without a beat.
  - A range that is entirely zero produces busy for range-length cycles, no beats, then done.
- Not defined: every index in the range produces a beat, including zero-valued ones.

Decomposition:
- Package regfile_pkg holds:
  - NUM_REGS, DATA_WIDTH, ADDR_WIDTH and XZR_IDX (NUM_REGS-1);
  - the dump_state_t enum {IDLE, STREAM, FINISH};
  - a function reg_slice(regs, idx) that returns one register, with XZR forced to 0.
- One sub-module, dump_addr_counter: loadable ADDR_WIDTH counter with enable, modulo-NUM_REGS wrap, and an at_last comparator output.

Test Plan:
- reset, then start with first=3, last=6, out_ready=1 constant -> beats addr 3,4,5,6 on consecutive cycles with matching data; done pulses once the cycle after addr 6; busy falls with done.
- first=30, last=1, regs[31]=0xFFFF_FFFF_FFFF_FFFF -> beats 30,31,0,1; beat 31 carries data 0.
- first=last=7, out_ready low for 4 cycles then high; regs[7] changes during the stall -> single beat, addr 7, data equal to the value at load time, held stable for all stall cycles.
- abort asserted on the second beat of range 0..10 -> out_valid and busy 0 the next cycle, no done; a new start one cycle later begins cleanly at its own first_addr.
- reset asserted asynchronously mid-dump (between clock edges) -> all outputs 0 immediately; no done after release.
- REGFILE_DUMP_SKIP_ZERO_EN defined, range 0..4, regs 1 and 3 non-zero -> exactly two beats (addr 1, addr 3), then done; without the macro -> five beats.
